// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
// Sequencing controller for a single-port instruction memory. After reset it
// holds the pipeline and streams a program image from the loader into the
// memory. It then hands the memory address port to the IF stage for fetch.
// A reload can be requested from RUN with ld_start.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   ld_start        reload request pulse (honoured only in RUN)
//   ld_valid/ld_data/ld_last/ld_ready   loader valid/ready stream
//   if_addr/if_inst/if_valid            fetch port (live only in RUN)
//   pipe_stall      hold PC and pipeline registers
//   mem_we/mem_addr/mem_wdata/mem_rdata single-port memory interface
//   ld_done         one-cycle pulse on entry to RUN
//   ld_count/ld_checksum/ld_err         status of the current/last image
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | just out of reset, pipeline held
// LOAD  | accepting loader words, one registered write per handshake
// FLUSH | last registered write commits, loader blocked
// RUN   | memory address port owned by the fetch stage
module imem_load_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              pipe_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic [DATA_W-1:0] ld_checksum,
  output logic              ld_err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_pend;
  logic              hs;
  logic              at_end;
  logic              reload;

  assign hs     = ld_valid & ld_ready;
  assign at_end = (ptr == ADDR_W'(DEPTH - 1));
  assign reload = (state == RUN) & ld_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    pipe_stall = 1'b1;
    if_valid   = 1'b0;
    case (state)
      IDLE:  state_nxt = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        // the write at DEPTH-1 always ends the load, last flag or not
        if (ld_valid && (ld_last || at_end)) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = RUN;
      RUN: begin
        pipe_stall = 1'b0;
        if_valid   = 1'b1;
        if (ld_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port mux: the registered write owns the port until RUN.
  always_comb begin
    mem_we    = wr_pend & (state != RUN);
    mem_addr  = (state == RUN) ? if_addr : wr_addr;
    mem_wdata = wr_data;
    if_inst   = (state == RUN) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_pend     <= 1'b0;
      ld_count    <= '0;
      ld_checksum <= '0;
      ld_err      <= 1'b0;
      ld_done     <= 1'b0;
    end else begin
      wr_pend <= hs;
      ld_done <= (state == FLUSH);
      if (reload) begin
        ptr         <= '0;
        ld_count    <= '0;
        ld_checksum <= '0;
        ld_err      <= 1'b0;
      end else if (hs) begin
        wr_addr     <= ptr;
        wr_data     <= ld_data;
        ptr         <= ptr + ADDR_W'(1);
        ld_count    <= ld_count + (ADDR_W+1)'(1);
        ld_checksum <= ld_checksum + ld_data;
        if (at_end && !ld_last) ld_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk;
  logic        reset;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  if_addr;
  logic [15:0] if_inst;
  logic        if_valid;
  logic        pipe_stall;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        ld_done;
  logic [8:0]  ld_count;
  logic [15:0] ld_checksum;
  logic        ld_err;

  imem_load_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .pipe_stall(pipe_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ld_done(ld_done),
    .ld_count(ld_count), .ld_checksum(ld_checksum), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port memory, combinational read
  logic [15:0] mem [256];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  exp_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // write monitor: every memory write must match the next queued handshake
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {8'h0, mem_addr, mem_wdata}, {8'h0, e});
      end
    end
  end

  // tasks are entered 1 time unit after a rising edge
  task automatic send(input logic [15:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (ld_ready) begin
        exp_q.push_back({exp_ptr, d});
        exp_ptr = exp_ptr + 8'd1;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic expect_finish();
    check("flush_ready", {31'd0, ld_ready}, 32'd0);
    check("flush_stall", {31'd0, pipe_stall}, 32'd1);
    check("flush_done", {31'd0, ld_done}, 32'd0);
    @(posedge clk); #1;
    check("run_done", {31'd0, ld_done}, 32'd1);
    check("run_stall", {31'd0, pipe_stall}, 32'd0);
    check("run_valid", {31'd0, if_valid}, 32'd1);
    @(posedge clk); #1;
    check("done_pulse_end", {31'd0, ld_done}, 32'd0);
  endtask

  task automatic start_reload();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    exp_ptr = 8'd0;
    check("reload_stall", {31'd0, pipe_stall}, 32'd1);
    check("reload_ready", {31'd0, ld_ready}, 32'd1);
    check("reload_valid", {31'd0, if_valid}, 32'd0);
    check("reload_count", {23'd0, ld_count}, 32'd0);
    check("reload_cksum", {16'd0, ld_checksum}, 32'd0);
    check("reload_err", {31'd0, ld_err}, 32'd0);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] req);
    if_addr = a;
    #1;
    check("fetch_inst", {16'd0, if_inst}, {16'd0, req});
    check("fetch_we", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic status(input logic [8:0] cnt, input logic [15:0] ck, input logic err);
    check("count", {23'd0, ld_count}, {23'd0, cnt});
    check("checksum", {16'd0, ld_checksum}, {16'd0, ck});
    check("err", {31'd0, ld_err}, {31'd0, err});
  endtask

  task automatic check_reset_values();
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_stall", {31'd0, pipe_stall}, 32'd1);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst", {16'd0, if_inst}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_done", {31'd0, ld_done}, 32'd0);
    status(9'd0, 16'h0000, 1'b0);
  endtask

  initial begin
    reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; if_addr = 8'd5; exp_ptr = 8'd0;
    #22;
    check_reset_values();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("load_after_reset", {31'd0, ld_ready}, 32'd1);

    // four-word image
    send(16'h1111, 1'b0); send(16'h2222, 1'b0);
    send(16'h3333, 1'b0); send(16'h4444, 1'b1);
    expect_finish();
    status(9'd4, 16'hAAAA, 1'b0);
    fetch(8'd2, 16'h3333);
    check("run_stall_fetch", {31'd0, pipe_stall}, 32'd0);

    // reload with two words; address 3 keeps the old word
    @(posedge clk); #1;
    start_reload();
    send(16'hFFFF, 1'b0); send(16'h0002, 1'b1);
    expect_finish();
    status(9'd2, 16'h0001, 1'b0);
    fetch(8'd3, 16'h4444);
    fetch(8'd0, 16'hFFFF);
    fetch(8'd1, 16'h0002);

    // valid toggled every other cycle, ld_start pulses during LOAD ignored
    @(posedge clk); #1;
    start_reload();
    for (int i = 1; i <= 5; i++) begin
      send(16'h0A00 + 16'(i), (i == 5));
      if (i < 5) begin
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        check("start_ignored_ready", {31'd0, ld_ready}, 32'd1);
      end
    end
    expect_finish();
    status(9'd5, 16'h320F, 1'b0);
    fetch(8'd4, 16'h0A05);

    // overflow: 256 words with no last flag
    @(posedge clk); #1;
    start_reload();
    for (int i = 0; i < 256; i++) send(16'h0101, 1'b0);
    expect_finish();
    status(9'd256, 16'h0100, 1'b1);
    fetch(8'd255, 16'h0101);

    // 256 words with last on the final one: normal end
    @(posedge clk); #1;
    start_reload();
    for (int i = 0; i < 256; i++) send(16'(i), (i == 255));
    expect_finish();
    status(9'd256, 16'h7F80, 1'b0);
    fetch(8'd200, 16'd200);

    // reset in the middle of a load
    @(posedge clk); #1;
    start_reload();
    send(16'h5A5A, 1'b0); send(16'h6B6B, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    exp_ptr = 8'd0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_restart_ready", {31'd0, ld_ready}, 32'd1);
    check("reset_restart_count", {23'd0, ld_count}, 32'd0);
    send(16'h7777, 1'b1);
    expect_finish();
    status(9'd1, 16'h7777, 1'b0);
    fetch(8'd0, 16'h7777);
    fetch(8'd1, 16'h0001);

    @(posedge clk); #1;
    check("pending_writes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
